// File: rtl/pulsar_bank.sv
// Multi-channel phase-staggered triangle/sawtooth compare generator with PWM peak strobes.
// Optional PULSAR_BANK_SYNC_EN adds a `sync` input that realigns all channels to their reset phases.

module pulsar_lane #(
  parameter int unsigned     WIDTH  = 12,
  parameter int unsigned     STEP_W = 4,
  parameter logic [WIDTH-1:0] PHASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_i,
  input  logic              adv_i,
  input  logic [1:0]        mode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  lo_i,
  input  logic [WIDTH-1:0]  hi_i,
  output logic [WIDTH-1:0]  ctr_o,
  output logic              peak_o
);
  typedef enum logic [1:0] {M_TRI = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_HOLD = 2'b11} mode_e;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  mode_e              mode;
  logic [WIDTH-1:0]   ctr_q, ctr_d;
  logic               dir_q, dir_d;
  logic               peak_q, peak_d;
  logic [WIDTH:0]     stp, sum, lo_x, hi_x;
  logic signed [WIDTH:0] diff;

  assign mode = mode_e'(mode_i);
  // A zero step would stall the sweep forever, so it counts as one.
  assign stp  = (step_i == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step_i);
  assign lo_x = {1'b0, lo_i};
  assign hi_x = {1'b0, hi_i};
  assign sum  = {1'b0, ctr_q} + stp;
  assign diff = $signed({1'b0, ctr_q}) - $signed(stp);

  always_comb begin
    ctr_d  = ctr_q;
    dir_d  = dir_q;
    peak_d = 1'b0;
    if (adv_i) begin
      if (lo_i >= hi_i) begin
        ctr_d = lo_i;
      end else if (mode != M_HOLD) begin
        if (mode == M_UP) dir_d = DIR_UP;
        if (mode == M_DN) dir_d = DIR_DN;
        if (ctr_q < lo_i || ctr_q > hi_i) begin
          ctr_d = (mode == M_DN) ? hi_i : lo_i;
        end else begin
          case (mode)
            M_TRI: begin
              if (dir_q == DIR_UP) begin
                if (sum >= hi_x) begin
                  ctr_d  = hi_i;
                  dir_d  = DIR_DN;
                  peak_d = 1'b1;
                end else ctr_d = sum[WIDTH-1:0];
              end else begin
                if (diff <= $signed(lo_x)) begin
                  ctr_d = lo_i;
                  dir_d = DIR_UP;
                end else ctr_d = diff[WIDTH-1:0];
              end
            end
            M_UP: begin
              if (sum > hi_x) begin
                ctr_d  = lo_i;
                peak_d = 1'b1;
              end else ctr_d = sum[WIDTH-1:0];
            end
            M_DN: begin
              if (diff < $signed(lo_x)) begin
                ctr_d  = hi_i;
                peak_d = 1'b1;
              end else ctr_d = diff[WIDTH-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q  <= PHASE;
      dir_q  <= DIR_UP;
      peak_q <= 1'b0;
    end else if (sync_i) begin
      ctr_q  <= PHASE;
      dir_q  <= DIR_UP;
      peak_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      dir_q  <= dir_d;
      peak_q <= peak_d;
    end
  end

  assign ctr_o  = ctr_q;
  assign peak_o = peak_q;
endmodule

module pulsar_bank #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef PULSAR_BANK_SYNC_EN
  input  logic                      sync,
`endif
  input  logic                      update,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [1:0]                mode,
  input  logic [STEP_W-1:0]         step,
  input  logic [WIDTH-1:0]          lo,
  input  logic [WIDTH-1:0]          hi,
  output logic [CHANNELS*WIDTH-1:0] cmp,
  output logic [CHANNELS-1:0]       peak
);
  localparam int unsigned PER = (2**WIDTH) / CHANNELS;

  logic [CHANNELS-1:0][WIDTH-1:0] cmp_w;
  logic                           sync_w;

`ifdef PULSAR_BANK_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    pulsar_lane #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W),
      .PHASE (WIDTH'(gi * PER))
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .sync_i(sync_w),
      .adv_i (update & enable[gi]),
      .mode_i(mode),
      .step_i(step),
      .lo_i  (lo),
      .hi_i  (hi),
      .ctr_o (cmp_w[gi]),
      .peak_o(peak[gi])
    );
  end

  assign cmp = cmp_w;
endmodule

// File: doc/pulsar_bank.md
Name: pulsar_bank

Overview:
Multi-channel successor to the single triangle-wave PWM compare generator. Each of CHANNELS counters sweeps between programmable bounds `lo` and `hi` with a programmable step, in triangle, sawtooth-up, sawtooth-down or hold mode. Channels start phase-staggered and feed one PWM comparator each, for example for LED breathing or multi-phase effects. Advance is gated by the shared `update` strobe from the prescaler.

Parameters:
WIDTH, 12, counter/compare width in bits
CHANNELS, 4, number of independent counters (1..16)
STEP_W, 4, width of the step input

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
update  in  1  advance strobe, sampled each clk edge
enable  in  CHANNELS  per-channel run enable; bit i gates channel i
mode  in  2  00 triangle, 01 saw up, 10 saw down, 11 hold (shared by all channels)
step  in  STEP_W  increment magnitude, zero-extended; 0 is treated as 1
lo  in  WIDTH  lower bound, inclusive
hi  in  WIDTH  upper bound, inclusive
cmp  out  CHANNELS*WIDTH  counter values; channel i at bits [i*WIDTH +: WIDTH]
peak  out  CHANNELS  one-clk pulse per channel on cycle/turn event

Behaviour:
- Reset (async, immediate):
  - ctr[i] = (i * (2^WIDTH / CHANNELS)) mod 2^WIDTH
  - dir[i] = up
  - peak = 0
- All outputs are registered. cmp/peak change on the clk edge where update=1 and enable[i]=1; that is 1 cycle of latency. Otherwise ctr holds and peak[i]=0.
- peak is high only on the cycle following the qualifying update.
- Arithmetic is done in WIDTH+1 bits, unsigned for sums and signed for differences; no modular wrap-through is ever permitted.
- Degenerate bounds: if lo >= hi, ctr[i] <= lo on every qualifying update and peak stays 0.
- Out of range: if ctr[i] < lo or ctr[i] > hi at a qualifying update, load lo (modes 00/01) or hi (mode 10); no peak.
- Triangle (00):
  - Up: if ctr+step >= hi, then ctr <= hi, dir <= down, peak=1; else ctr <= ctr+step.
  - Down: if ctr-step <= lo, then ctr <= lo, dir <= up; else ctr <= ctr-step.
- Saw up (01): if ctr+step > hi, then ctr <= lo and peak=1; else ctr <= ctr+step. dir forced up.
- Saw down (10): if ctr-step < lo, then ctr <= hi and peak=1; else ctr <= ctr-step. dir forced down.
- Hold (11): ctr and dir unchanged, peak=0.
- Mode change mid-sweep takes effect on the next qualifying update. Entering triangle keeps the stored dir.
- lo/hi/step changes take effect on the next qualifying update; there is no shadowing.
- Reset asserted mid-operation overrides everything, including update. Deassertion is used directly; the reset synchroniser lives upstream.

Optional Feature:
PULSAR_BANK_SYNC_EN
- Defined: adds port `sync in 1`. When sync=1 at a clk edge, all channels reload their reset phase values, dir <= up and peak <= 0, regardless of update/enable/mode. sync has priority over update.
- Undefined: port absent; phases realign only via rst.

Test Plan:
- rst pulse, defaults -> cmp = {3072, 2048, 1024, 0} immediately, without a clk edge; peak = 0.
- lo=0, hi=4095, step=1, mode=00, update every cycle -> ch0: 1, 2, ... 4095 (peak0=1 that cycle), then 4094, 4093; ch3 peaks after 1023 updates.
- lo=10, hi=20, step=3, mode=00 -> ch0 sequence 10 (out of range load), 13, 16, 19, 20 (peak), 17, 14, 11, 10, 13.
- lo=0, hi=9, step=4, mode=01 on ch0 at 0 -> 4, 8, 0 (peak), 4; then mode=10 -> 0, 9 (peak), 5, 1, 9 (peak).
- step=0 -> behaves as step=1. mode=11, or enable[2]=0, or update=0 for 50 cycles -> affected cmp frozen, peak=0. lo=30, hi=30 -> ctr=30, no peak.
- With PULSAR_BANK_SYNC_EN: sync=1 together with update=1 mid-sweep -> next cycle cmp = reset phases and dir up. Next update -> ch0 = lo if out of range, otherwise 1 step up.
